// File: rtl/baud_ctrl_pkg.sv
// rtl/baud_ctrl_pkg.sv - shared types and constants for the baud divisor controller
//
// Purpose : FSM state encoding, default-divisor computation and the
//           oversample shift used to turn a start-bit length into a divisor.
// Ports   : none (package).

package baud_ctrl_pkg;

    localparam int unsigned DEF_FREQUENCY     = 50_000_000;
    localparam int unsigned DEF_BAUDRATE      = 9600;
    localparam int unsigned DEF_SAMPLED_TIMES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_FALL,
        ST_MEASURE,
        ST_CALC
    } baud_state_e;

    // Truncating divide: 50 MHz / (9600 * 16) = 325.
    function automatic int unsigned calc_default_div(
        input int unsigned freq,
        input int unsigned baud,
        input int unsigned sampled
    );
        return freq / (baud * sampled);
    endfunction

    // Right shift equivalent to dividing by the oversample factor.
    // The factor is a power of two, so the log2 is exact.
    function automatic int os_shift(input int unsigned sampled);
        return $clog2(sampled);
    endfunction

endpackage

// File: rtl/baud_tick_divider.sv
// rtl/baud_tick_divider.sv - programmable down-counter producing the oversample tick
//
// Purpose : o_tick is high in exactly the cycle the counter sits at zero; the
//           counter then reloads i_div-1, giving a period of i_div clocks.
//           A load forces the counter to i_load_div-1 so a new divisor starts
//           a full period at once instead of finishing the old one.
// Ports   : i_clk, i_reset_n  clock and synchronous active-low reset
//           i_load            load strobe (divisor commit)
//           i_load_div        divisor being committed
//           i_div             divisor in force for periodic reloads
//           o_tick            one-cycle oversample tick

module baud_tick_divider #(
    parameter int          NB_DIV    = 16,
    parameter int unsigned RESET_DIV = 325
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [NB_DIV-1:0] i_load_div,
    input  logic [NB_DIV-1:0] i_div,
    output logic              o_tick
);

    logic [NB_DIV-1:0] cnt;

    assign o_tick = (cnt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt <= NB_DIV'(RESET_DIV - 1);
        end else if (i_load) begin
            cnt <= i_load_div - NB_DIV'(1);
        end else if (o_tick) begin
            cnt <= i_div - NB_DIV'(1);
        end else begin
            cnt <= cnt - NB_DIV'(1);
        end
    end

endmodule

// File: rtl/baud_autobaud_ctrl.sv
// rtl/baud_autobaud_ctrl.sv - baud divisor owner with manual load and start-bit auto-baud
//
// Purpose : Holds the active divisor and generates the oversample tick from it.
//           The divisor changes by a host write, or by timing the start bit
//           of a 0x55 sync character: the low time N in clocks is one bit,
//           so divisor = round(N / SAMPLED_TIMES).
// Ports   : i_clk, i_reset_n  clock and synchronous active-low reset
//           i_rx              asynchronous RX line, idle high
//           i_start_auto      pulse: begin auto-baud
//           i_div_wr, i_div   pulse + value: manual divisor write
//           o_tick            one-cycle oversample tick
//           o_divisor         active divisor
//           o_busy            auto-baud in progress
//           o_locked          divisor came from a successful auto-baud
//           o_error           sticky error flag

module baud_autobaud_ctrl
    import baud_ctrl_pkg::*;
#(
    parameter int unsigned FREQUENCY     = DEF_FREQUENCY,
    parameter int unsigned BAUDRATE      = DEF_BAUDRATE,
    parameter int unsigned SAMPLED_TIMES = DEF_SAMPLED_TIMES,
    parameter int          NB_DIV        = 16,
    parameter int          NB_MEAS       = 20,
    parameter int unsigned DEFAULT_DIV   = calc_default_div(FREQUENCY, BAUDRATE, SAMPLED_TIMES)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rx,
    input  logic              i_start_auto,
    input  logic              i_div_wr,
    input  logic [NB_DIV-1:0] i_div,
    output logic              o_tick,
    output logic [NB_DIV-1:0] o_divisor,
    output logic              o_busy,
    output logic              o_locked,
    output logic              o_error
);

    localparam int                 OS_SHIFT   = os_shift(SAMPLED_TIMES);
    localparam int                 SUM_W      = NB_MEAS + 1;
    localparam logic [NB_MEAS-1:0] MEAS_MAX   = '1;
    localparam logic [NB_MEAS-1:0] MEAS_MIN   = NB_MEAS'(2 * SAMPLED_TIMES);
    localparam logic [SUM_W-1:0]   ROUND_HALF = SUM_W'(SAMPLED_TIMES / 2);

    baud_state_e         state;
    logic                rx_meta;
    logic                rx_s;
    logic                rx_prev;
    logic [NB_MEAS-1:0]  count;
    logic [NB_DIV-1:0]   div_q;
    logic                busy_q;
    logic                locked_q;
    logic                error_q;

    logic                rx_fall;
    logic                rx_rise;
    logic                wr_ok;
    logic [SUM_W-1:0]    meas_sum;
    logic [NB_MEAS-1:0]  calc_div;
    logic                calc_bad;
    logic                commit;
    logic [NB_DIV-1:0]   commit_div;

    assign rx_fall = rx_prev & ~rx_s;
    assign rx_rise = ~rx_prev & rx_s;
    assign wr_ok   = i_div_wr && (i_div != '0);

    // One extra bit on the rounding sum keeps a measurement near full scale
    // from wrapping before the shift.
    always_comb begin
        meas_sum = {1'b0, count} + ROUND_HALF;
        calc_div = NB_MEAS'(meas_sum >> OS_SHIFT);
        calc_bad = (count < MEAS_MIN) || ((calc_div >> NB_DIV) != '0);
    end

    // A valid host write wins in every state (load in idle, abort when busy);
    // otherwise only a good CALC result commits.
    always_comb begin
        commit     = 1'b0;
        commit_div = i_div;
        if (wr_ok) begin
            commit = 1'b1;
        end else if ((state == ST_CALC) && !calc_bad) begin
            commit     = 1'b1;
            commit_div = NB_DIV'(calc_div);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            count    <= '0;
            div_q    <= NB_DIV'(DEFAULT_DIV);
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            if (commit) begin
                div_q <= commit_div;
            end

            if (wr_ok) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                locked_q <= 1'b0;
                error_q  <= 1'b0;
            end else begin
                // A zero divisor is never loaded; it only flags the error,
                // and a running measurement carries on.
                if (i_div_wr) begin
                    error_q <= 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (i_start_auto && !i_div_wr) begin
                            state    <= ST_ARM;
                            busy_q   <= 1'b1;
                            locked_q <= 1'b0;
                            error_q  <= 1'b0;
                        end
                    end

                    // Wait for an idle line so a fall seen later is a real start bit.
                    ST_ARM: begin
                        if (rx_s) begin
                            state <= ST_WAIT_FALL;
                        end
                    end

                    ST_WAIT_FALL: begin
                        if (rx_fall) begin
                            state <= ST_MEASURE;
                            count <= NB_MEAS'(1);
                        end
                    end

                    ST_MEASURE: begin
                        if (count == MEAS_MAX) begin
                            state   <= ST_IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else if (rx_rise) begin
                            state <= ST_CALC;
                        end else begin
                            count <= count + NB_MEAS'(1);
                        end
                    end

                    ST_CALC: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        if (calc_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            locked_q <= 1'b1;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    baud_tick_divider #(
        .NB_DIV    (NB_DIV),
        .RESET_DIV (DEFAULT_DIV)
    ) u_tick_divider (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (commit),
        .i_load_div (commit_div),
        .i_div      (div_q),
        .o_tick     (o_tick)
    );

    assign o_divisor = div_q;
    assign o_busy    = busy_q;
    assign o_locked  = locked_q;
    assign o_error   = error_q;

endmodule

// File: tb/tb_baud_autobaud_ctrl.sv
// tb/tb_baud_autobaud_ctrl.sv - self-checking bench for baud_autobaud_ctrl

module tb_baud_autobaud_ctrl;

    localparam int DEF_DIV = 325;
    localparam int OS      = 16;
    // Edges from driving i_rx high to the divisor commit: two synchronizer
    // flops, one to see the rising edge, one for the CALC cycle.
    localparam int COMMIT_LAT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        rx, start_auto, div_wr;
    logic [15:0] div_in;
    logic        tick, busy, locked, error;
    logic [15:0] divisor;

    logic        rx2, start2, div_wr2;
    logic [15:0] div2;
    logic        tick2, busy2, locked2, error2;
    logic [15:0] divisor2;

    baud_autobaud_ctrl dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_rx         (rx),
        .i_start_auto (start_auto),
        .i_div_wr     (div_wr),
        .i_div        (div_in),
        .o_tick       (tick),
        .o_divisor    (divisor),
        .o_busy       (busy),
        .o_locked     (locked),
        .o_error      (error)
    );

    baud_autobaud_ctrl #(.NB_MEAS(12)) dut12 (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_rx         (rx2),
        .i_start_auto (start2),
        .i_div_wr     (div_wr2),
        .i_div        (div2),
        .o_tick       (tick2),
        .o_divisor    (divisor2),
        .o_busy       (busy2),
        .o_locked     (locked2),
        .o_error      (error2)
    );

    int n_checks;
    int n_errors;

    // Reference model: divisor in force, clocks since its period started,
    // and a scheduled auto-baud commit (countdown in edges, 0 = none).
    int m_div;
    int m_since;
    int m2_since;
    int pend;
    int pend_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance the model on the edge, check tick/divisor every cycle.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            m_div    = DEF_DIV;
            m_since  = 0;
            m2_since = 0;
            pend     = 0;
        end else begin
            m2_since++;
            if (div_wr && div_in != 16'd0) begin
                m_div   = int'(div_in);
                m_since = 0;
                pend    = 0;
            end else if (pend == 1) begin
                m_div   = pend_val;
                m_since = 0;
                pend    = 0;
            end else begin
                m_since++;
                if (pend > 1) pend--;
            end
        end
        #1;
        check_eq("tick", tick, (m_since % m_div) == m_div - 1);
        check_eq("divisor", divisor, m_div);
        check_eq("tick_nb12", tick2, (m2_since % DEF_DIV) == DEF_DIV - 1);
        div_wr     = 1'b0;
        start_auto = 1'b0;
        start2     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        rx2     = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        check_eq("rst_div", divisor, DEF_DIV);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_error", error, 0);
    endtask

    task automatic run_autobaud(input int low_len, input bit zero_mid);
        int exp_div;
        int prev_div;
        bit ok;
        exp_div  = (low_len + OS / 2) / OS;
        ok       = (low_len >= 2 * OS) && (exp_div <= 65535);
        prev_div = m_div;
        start_auto = 1'b1;
        step();
        check_eq("ab_busy_start", busy, 1);
        check_eq("ab_locked_start", locked, 0);
        check_eq("ab_error_start", error, 0);
        rx = 1'b1;
        repeat (5) step();
        rx = 1'b0;
        for (int i = 0; i < low_len; i++) begin
            if (zero_mid && i == low_len / 2) begin
                div_wr = 1'b1;
                div_in = 16'd0;
            end
            step();
        end
        rx = 1'b1;
        if (ok) begin
            pend     = COMMIT_LAT;
            pend_val = exp_div;
        end
        repeat (8) step();
        check_eq("ab_busy_end", busy, 0);
        check_eq("ab_locked", locked, ok);
        check_eq("ab_error", error, !ok || zero_mid);
        check_eq("ab_divisor", divisor, ok ? exp_div : prev_div);
    endtask

    initial begin
        int d;
        int len;
        n_checks = 0;
        n_errors = 0;
        m_div = DEF_DIV; m_since = 0; m2_since = 0; pend = 0; pend_val = 0;
        reset_n = 1'b0; rx = 1'b1; rx2 = 1'b1;
        start_auto = 1'b0; start2 = 1'b0; div_wr = 1'b0; div_wr2 = 1'b0;
        div_in = 16'd0; div2 = 16'd0;

        do_reset();
        repeat (700) step();

        // Manual writes, zero write, and write-vs-start priority.
        div_wr = 1'b1; div_in = 16'd10;
        step();
        check_eq("wr10_div", divisor, 10);
        check_eq("wr10_error", error, 0);
        repeat (35) step();
        div_wr = 1'b1; div_in = 16'd0;
        step();
        check_eq("wr0_error", error, 1);
        check_eq("wr0_div", divisor, 10);
        repeat (25) step();
        div_wr = 1'b1; div_in = 16'd0; start_auto = 1'b1;
        step();
        check_eq("wr0_start_busy", busy, 0);
        check_eq("wr0_start_error", error, 1);
        div_wr = 1'b1; div_in = 16'd7; start_auto = 1'b1;
        step();
        check_eq("wr7_start_busy", busy, 0);
        check_eq("wr7_start_error", error, 0);
        repeat (20) step();
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 1 : int'($urandom_range(2, 60));
            div_wr = 1'b1; div_in = 16'(d);
            step();
            check_eq("rnd_wr_locked", locked, 0);
            repeat (3 * d + int'($urandom_range(0, 4))) step();
        end

        // Auto-baud: nominal 9600 start bit, too-short pulses, boundary, random.
        do_reset();
        run_autobaud(5208, 1'b0);
        repeat (700) step();
        do_reset();
        run_autobaud(20, 1'b0);
        repeat (400) step();
        run_autobaud(31, 1'b0);
        run_autobaud(32, 1'b0);
        repeat (20) step();
        run_autobaud(int'($urandom_range(33, 1200)), 1'b1);
        repeat (200) step();
        for (int i = 0; i < 3; i++) begin
            len = int'($urandom_range(10, 1500));
            run_autobaud(len, 1'b0);
            repeat (2 * m_div + 10) step();
        end

        // Measurement overflow on the 12-bit instance.
        start2 = 1'b1;
        step();
        check_eq("ovf_busy_start", busy2, 1);
        rx2 = 1'b1;
        repeat (5) step();
        rx2 = 1'b0;
        repeat (4090) step();
        check_eq("ovf_busy_mid", busy2, 1);
        check_eq("ovf_error_mid", error2, 0);
        repeat (20) step();
        check_eq("ovf_busy_end", busy2, 0);
        check_eq("ovf_error", error2, 1);
        check_eq("ovf_locked", locked2, 0);
        check_eq("ovf_div", divisor2, DEF_DIV);
        rx2 = 1'b1;
        repeat (10) step();

        // Abort by manual write during measurement.
        do_reset();
        start_auto = 1'b1;
        step();
        rx = 1'b1;
        repeat (5) step();
        rx = 1'b0;
        repeat (100) step();
        div_wr = 1'b1; div_in = 16'd0;
        step();
        check_eq("busy_wr0_error", error, 1);
        check_eq("busy_wr0_busy", busy, 1);
        start_auto = 1'b1;
        step();
        check_eq("busy_start_busy", busy, 1);
        div_wr = 1'b1; div_in = 16'd50;
        step();
        check_eq("abort_div", divisor, 50);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_locked", locked, 0);
        rx = 1'b1;
        repeat (40) step();
        check_eq("abort_late_div", divisor, 50);
        check_eq("abort_late_locked", locked, 0);
        check_eq("abort_late_busy", busy, 0);

        // Reset during measurement.
        start_auto = 1'b1;
        step();
        repeat (5) step();
        rx = 1'b0;
        repeat (200) step();
        div_wr = 1'b1; div_in = 16'd0;
        step();
        check_eq("mrst_pre_error", error, 1);
        reset_n = 1'b0;
        step();
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_locked", locked, 0);
        check_eq("mrst_error", error, 0);
        check_eq("mrst_div", divisor, DEF_DIV);
        reset_n = 1'b1;
        rx = 1'b1;
        repeat (400) step();
        check_eq("mrst_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
